// File: rtl/popcount_seq.sv
// popcount_seq: sequential bit counter. Counts the bits of a captured operand that equal a
// selected value (ones or zeros), CHUNK bits per clock, LSB chunk first.
//
// Optional build macro POPCNT_FIRST_IDX_EN adds out_found/out_first, reporting the lowest bit
// index that matched.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset (aborts any operation in flight)
//   in_valid   - request present
//   in_ready   - block can accept a request (high only when idle)
//   in_value   - operand word, captured on accept
//   in_what    - bit value to count (1 = ones, 0 = zeros), captured on accept
//   out_valid  - result present (held until out_ready)
//   out_ready  - consumer accepts the result
//   out_count  - number of operand bits equal to in_what
//   out_found  - (macro only) at least one bit matched
//   out_first  - (macro only) lowest matching bit index, 0 when none matched
module popcount_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic          in_what,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count
`ifdef POPCNT_FIRST_IDX_EN
  ,
  output logic          out_found,
  output logic [IW-1:0] out_first
`endif
);

  localparam int NCH = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || (((CHUNK < 1) ? 0 : (WIDTH % CHUNK)) != 0)) begin : g_param_check
    $error("popcount_seq: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e state_q, state_d;
  // Operand stored as an array of chunks so the current chunk is a plain index by k.
  logic [NCH-1:0][CHUNK-1:0] value_q, value_d;
  logic                      what_q, what_d;
  logic [CW-1:0]             acc_q, acc_d;
  logic [KW-1:0]             k_q, k_d;

  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    chunk_cnt;

`ifdef POPCNT_FIRST_IDX_EN
  logic          found_q, found_d;
  logic [IW-1:0] first_q, first_d;
  logic          chunk_hit;
  int            chunk_lo;
`endif

  // Per-chunk match count. Case equality makes X/Z operand bits count as non-matching.
  always_comb begin
    chunk     = value_q[k_q];
    chunk_cnt = '0;
`ifdef POPCNT_FIRST_IDX_EN
    chunk_hit = 1'b0;
    chunk_lo  = 0;
`endif
    // Scan high to low so the last hit recorded is the lowest index in the chunk.
    for (int b = CHUNK - 1; b >= 0; b--) begin
      if (what_q ? (chunk[b] === 1'b1) : (chunk[b] === 1'b0)) begin
        chunk_cnt = chunk_cnt + CW'(1);
`ifdef POPCNT_FIRST_IDX_EN
        chunk_hit = 1'b1;
        chunk_lo  = b;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    what_d  = what_q;
    acc_d   = acc_q;
    k_d     = k_q;
`ifdef POPCNT_FIRST_IDX_EN
    found_d = found_q;
    first_d = first_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          value_d = in_value;
          what_d  = in_what;
          acc_d   = '0;
          k_d     = '0;
`ifdef POPCNT_FIRST_IDX_EN
          found_d = 1'b0;
          first_d = '0;
`endif
          state_d = StCount;
        end
      end
      StCount: begin
        // Sum of all chunks is at most WIDTH, which CW bits always hold.
        acc_d = acc_q + chunk_cnt;
`ifdef POPCNT_FIRST_IDX_EN
        if (!found_q && chunk_hit) begin
          found_d = 1'b1;
          first_d = IW'(int'(k_q) * CHUNK + chunk_lo);
        end
`endif
        if (k_q == KW'(NCH - 1)) begin
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      value_q <= '0;
      what_q  <= 1'b0;
      acc_q   <= '0;
      k_q     <= '0;
`ifdef POPCNT_FIRST_IDX_EN
      found_q <= 1'b0;
      first_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      what_q  <= what_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
`ifdef POPCNT_FIRST_IDX_EN
      found_q <= found_d;
      first_q <= first_d;
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_count = acc_q;
`ifdef POPCNT_FIRST_IDX_EN
    out_found = found_q;
    out_first = first_q;
`endif
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Testbench for popcount_seq: table-driven vectors plus random vectors through a scoreboard,
// a 32-bit single-chunk instance, result hold with back-pressure, and reset abort.
module tb_popcount_seq;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int NCH = W / C;
  localparam int CW  = 4;
  localparam int IW  = 3;

  typedef struct {
    logic [W-1:0]  value;
    logic          what;
    logic [CW-1:0] count;
    logic          found;
    logic [IW-1:0] first;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic          in_valid, in_ready, in_what, out_valid, out_ready;
  logic [W-1:0]  in_value;
  logic [CW-1:0] out_count;
`ifdef POPCNT_FIRST_IDX_EN
  logic          out_found;
  logic [IW-1:0] out_first;
`endif

  logic        b_in_valid, b_in_ready, b_in_what, b_out_valid, b_out_ready;
  logic [31:0] b_in_value;
  logic [5:0]  b_out_count;
`ifdef POPCNT_FIRST_IDX_EN
  logic        b_out_found;
  logic [4:0]  b_out_first;
`endif

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_what   (in_what),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
`ifdef POPCNT_FIRST_IDX_EN
    ,
    .out_found (out_found),
    .out_first (out_first)
`endif
  );

  popcount_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_value  (b_in_value),
    .in_what   (b_in_what),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_count (b_out_count)
`ifdef POPCNT_FIRST_IDX_EN
    ,
    .out_found (b_out_found),
    .out_first (b_out_first)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t sb_q[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: straight bit-by-bit scan of the whole word.
  function automatic vec_t model(input logic [W-1:0] v, input logic w);
    vec_t r;
    r.value = v;
    r.what  = w;
    r.count = '0;
    r.found = 1'b0;
    r.first = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i] == w) begin
        r.count = r.count + 4'd1;
        if (!r.found) begin
          r.found = 1'b1;
          r.first = 3'(i);
        end
      end
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle. Latency is the number of negedges from the accept
  // edge up to the first one where out_valid is high, i.e. the edge that samples the result.
  task automatic do_op(input vec_t e, input int hold);
    int   lat;
    vec_t x;
    in_value = e.value;
    in_what  = e.what;
    in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("accept_ready", in_ready, 1);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = ~e.value;
    in_what  = ~e.what;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NCH + 1);
    x = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_count", out_count, x.count);
    end
    in_valid = 1'b0;
    chk("count", out_count, x.count);
`ifdef POPCNT_FIRST_IDX_EN
    chk("found", out_found, x.found);
    chk("first", out_first, x.first);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [W-1:0] rv;
    logic        rw;

    tbl[0] = '{8'h00, 1'b1, 4'd0, 1'b0, 3'd0};
    tbl[1] = '{8'h3C, 1'b1, 4'd4, 1'b1, 3'd2};
    tbl[2] = '{8'hBD, 1'b0, 4'd2, 1'b1, 3'd1};
    tbl[3] = '{8'hFF, 1'b1, 4'd8, 1'b1, 3'd0};
    tbl[4] = '{8'hFF, 1'b0, 4'd0, 1'b0, 3'd0};
    tbl[5] = '{8'h80, 1'b1, 4'd1, 1'b1, 3'd7};
    tbl[6] = '{8'h01, 1'b0, 4'd7, 1'b1, 3'd1};
    tbl[7] = '{8'hA5, 1'b1, 4'd4, 1'b1, 3'd0};
    tbl[8] = '{8'h00, 1'b0, 4'd8, 1'b1, 3'd0};

    in_valid = 1'b0; in_value = '0; in_what = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_value = '0; b_in_what = 1'b0; b_out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
`ifdef POPCNT_FIRST_IDX_EN
    chk("rst_found", out_found, 0);
    chk("rst_first", out_first, 0);
`endif
    chk("rst32_in_ready", b_in_ready, 1);
    chk("rst32_out_count", b_out_count, 0);
    rst_n = 1'b1;

    // First request is offered right after reset release; it must go on the first edge.
    for (int i = 0; i < 9; i++) do_op(tbl[i], (i == 2) ? 3 : 0);

    repeat (6) begin
      rv = W'($urandom);
      rw = 1'($urandom);
      do_op(model(rv, rw), 0);
    end

    // Single-chunk 32-bit instance: all ones must give 32 without wrapping.
    b_in_value = 32'hFFFF_FFFF;
    b_in_what  = 1'b1;
    b_in_valid = 1'b1;
    chk("w32_ready", b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_value = '0;
    lat = 1;
    while (!b_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w32_latency", lat, 2);
    chk("w32_count", b_out_count, 32);
`ifdef POPCNT_FIRST_IDX_EN
    chk("w32_found", b_out_found, 1);
    chk("w32_first", b_out_first, 0);
`endif
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("w32_release", b_out_valid, 0);

    // Reset pulse mid-COUNT aborts the operation.
    in_value = 8'h3C;
    in_what  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_count", out_count, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    do_op(tbl[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
